bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Drives a 4-digit multiplexed seven-segment display from the RTC's four BCD
//  time digits (MM:SS). This is the output end of the digit interface that the
//  switch-loading path fills. It scans one digit per slot, blanks the display
//  between slots against ghosting, and latches a frame snapshot so digits never tear.
// PARAMETERS
//  REFRESH_DIV      50000  clock cycles per digit slot; legal range >= 2
//  BLANK_CYCLES     500    cycles at the start of each slot with anodes off; 1 <= BLANK_CYCLES < REFRESH_DIV
//  SEG_ACTIVE_LOW   1      1: segments and dp drive 0 = lit; 0: active-high
//  ANODE_ACTIVE_LOW 1      1: anode_select drives 0 = enabled; 0: active-high
// PORTS
//  clock           in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  digit_second_0  in   4  BCD seconds units
//  digit_second_1  in   4  BCD seconds tens
//  digit_minute_0  in   4  BCD minutes units
//  digit_minute_1  in   4  BCD minutes tens
//  anode_select    out  4  one-hot digit enable; bit0 = second_0 ... bit3 = minute_1
//  segments        out  7  {g,f,e,d,c,b,a}
//  decimal_point   out  1  separator, lit only in the minute_0 slot
//  frame_done      out  1  one-cycle pulse each time a new frame snapshot is taken
// BEHAVIOUR
//  - One clock domain. Reset is synchronous, active-high. All outputs are registered.
//  - Reset values:
//    - cnt = 0, slot = SCAN_S0, shadow digits = 0.
//    - anode_select, segments and decimal_point are all inactive (1111 / 1111111 / 1
//      with active-low defaults).
//    - frame_done = 0.
//  - cnt counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, slot advances
//    S0 -> S1 -> M0 -> M1 -> S0.
//  - Snapshot: on every clock edge where cnt==0 and slot==S0, all four inputs load
//    into the shadow registers and frame_done is set for the following cycle only.
//    This includes the first cycle after reset is released.
//  - Input changes mid-frame have no effect until the next snapshot.
//  - Output at cycle t reflects the cnt/slot of cycle t-1 (1-cycle latency).
//    - cnt < BLANK_CYCLES: all anodes inactive, segments inactive, dp inactive.
//    - otherwise: the anode of the current slot is active, segments = decode(shadow
//      digit of that slot), dp active iff slot==M0.
//  - Decode:
//    - 0..9 map to the standard glyphs.
//    - 4'hA..4'hF map to a dash (segment g only).
//    - Polarity is applied after decoding, per SEG_ACTIVE_LOW and ANODE_ACTIVE_LOW.
//  - Reset asserted mid-slot or mid-frame: the next cycle returns to reset values.
//    Scanning restarts at S0 with a fresh snapshot.
//  - Full frame period = 4*REFRESH_DIV cycles. frame_done period is exactly that.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined: in slot M1, when the shadow digit_minute_1 == 0,
//    the anode stays inactive and segments stay inactive for the whole slot.
//    Timing is unchanged.
//  - LEADING_ZERO_BLANK_EN undefined: M1 always displays its digit, so 0 shows "0".
// STRUCTURE
//  - Package rtc_display_pkg holds:
//    - typedef logic [3:0] bcd_t;
//    - typedef enum logic [1:0] {SCAN_S0, SCAN_S1, SCAN_M0, SCAN_M1} scan_slot_t;
//    - active-high glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
//  - Sub-module bcd_to_seven_segment: combinational bcd_t -> active-high 7-bit glyph,
//    instantiated once on the mux output.
//  - Top level holds the counter, slot FSM, shadow registers, polarity and output registers.
// TESTING  (REFRESH_DIV=8, BLANK_CYCLES=2, active-low defaults)
//  - Reset held 3 cycles -> anode_select=1111, segments=1111111, decimal_point=1,
//    frame_done=0 on every reset cycle.
//  - Inputs S0=5, S1=9, M0=3, M1=1 ->
//    - anode sequence 1110, 1101, 1011, 0111, each active 6 cycles after 2 blank cycles;
//    - slot S0 segments = 0010010;
//    - dp=0 only while anode=1011;
//    - frame_done pulses every 32 cycles.
//  - digit_second_1 = 4'hC -> segments = 0111111 (dash) during the S1 slot.
//  - Change digit_second_0 from 5 to 7 during slot M0 -> the S0 slot keeps showing 5
//    until frame_done, then shows 1111000.
//  - Reset pulse during slot M0 -> outputs return to reset values next cycle.
//    First non-blank anode after release is 1110; frame_done fires 1 cycle after release.
//  - digit_minute_1 = 0:
//    - LEADING_ZERO_BLANK_EN defined -> anode stays 1111 for the whole M1 slot;
//    - undefined -> anode 0111 with segments = 1000000.

Source files
------------

// File: rtl/rtc_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_display_pkg
// Purpose  : Shared types and glyph constants for the RTC seven-segment
//            display path. Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rtc_display_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    SCAN_S0 = 2'd0,
    SCAN_S1 = 2'd1,
    SCAN_M0 = 2'd2,
    SCAN_M1 = 2'd3
  } scan_slot_t;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seven_segment.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seven_segment
// Purpose  : Combinational BCD digit to active-high seven-segment glyph.
//            Non-decimal codes (A..F) render as a dash.
// Ports    : i_digit  in  4  BCD digit
//            o_glyph  out 7  active-high glyph {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seven_segment
  import rtc_display_pkg::*;
(
  input  bcd_t       i_digit,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = SEG_DASH;
    case (i_digit)
      4'd0:    o_glyph = SEG_0;
      4'd1:    o_glyph = SEG_1;
      4'd2:    o_glyph = SEG_2;
      4'd3:    o_glyph = SEG_3;
      4'd4:    o_glyph = SEG_4;
      4'd5:    o_glyph = SEG_5;
      4'd6:    o_glyph = SEG_6;
      4'd7:    o_glyph = SEG_7;
      4'd8:    o_glyph = SEG_8;
      4'd9:    o_glyph = SEG_9;
      default: o_glyph = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Scans four BCD time digits (MM:SS) onto a multiplexed 4-digit
//            seven-segment display. One digit per slot of REFRESH_DIV cycles,
//            the first BLANK_CYCLES of every slot dark (anti-ghosting), and a
//            snapshot of all four digits taken at the start of each frame so
//            a displayed time never tears.
// Config   : LEADING_ZERO_BLANK_EN - when defined, the minute-tens digit is
//            left dark for its whole slot if its snapshot value is 0.
// Ports    : clock           in   1  system clock
//            reset           in   1  synchronous active-high reset
//            digit_second_0  in   4  BCD seconds units
//            digit_second_1  in   4  BCD seconds tens
//            digit_minute_0  in   4  BCD minutes units
//            digit_minute_1  in   4  BCD minutes tens
//            anode_select    out  4  one-hot digit enable (bit0 = second_0)
//            segments        out  7  {g,f,e,d,c,b,a}
//            decimal_point   out  1  separator, lit in the minute_0 slot
//            frame_done      out  1  one-cycle pulse per frame snapshot
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
  import rtc_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES     = 500,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  bcd_t       digit_second_0,
  input  bcd_t       digit_second_1,
  input  bcd_t       digit_minute_0,
  input  bcd_t       digit_minute_1,
  output logic [3:0] anode_select,
  output logic [6:0] segments,
  output logic       decimal_point,
  output logic       frame_done
);

  localparam int unsigned      c_CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(BLANK_CYCLES);
  localparam logic [3:0]       c_ANODE_OFF = ANODE_ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam logic [6:0]       c_SEG_OFF   = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic             c_DP_OFF    = SEG_ACTIVE_LOW;

  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  scan_slot_t         slot_q, slot_d;
  bcd_t [3:0]         shadow_q, shadow_d;   // index = slot encoding
  logic [3:0]         anode_q, anode_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_done_q, frame_done_d;

  logic               w_snapshot;
  logic               w_lit;
  logic [3:0]         w_anode_onehot;
  bcd_t               w_digit;
  logic [6:0]         w_glyph;

  // Digit of the current slot comes from the frame snapshot, never the live inputs.
  assign w_digit = shadow_q[slot_q];

  bcd_to_seven_segment u_decode (
    .i_digit (w_digit),
    .o_glyph (w_glyph)
  );

  always_comb begin
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;

    // Slot timing
    if (cnt_q == c_CNT_MAX) begin
      cnt_d = '0;
      case (slot_q)
        SCAN_S0: slot_d = SCAN_S1;
        SCAN_S1: slot_d = SCAN_M0;
        SCAN_M0: slot_d = SCAN_M1;
        default: slot_d = SCAN_S0;
      endcase
    end else begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end

    // Frame snapshot at the first cycle of slot S0
    w_snapshot = (cnt_q == '0) && (slot_q == SCAN_S0);
    if (w_snapshot) begin
      shadow_d     = {digit_minute_1, digit_minute_0, digit_second_1, digit_second_0};
      frame_done_d = 1'b1;
    end

    // Display drive, computed from this cycle's cnt/slot and registered
    w_lit = (cnt_q >= c_BLANK_END);
`ifdef LEADING_ZERO_BLANK_EN
    if ((slot_q == SCAN_M1) && (shadow_q[3] == 4'd0)) begin
      w_lit = 1'b0;
    end
`endif
    w_anode_onehot = 4'b0001 << slot_q;

    if (w_lit) begin
      anode_d = ANODE_ACTIVE_LOW ? ~w_anode_onehot : w_anode_onehot;
      seg_d   = SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
      dp_d    = (slot_q == SCAN_M0) ? ~c_DP_OFF : c_DP_OFF;
    end else begin
      anode_d = c_ANODE_OFF;
      seg_d   = c_SEG_OFF;
      dp_d    = c_DP_OFF;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      slot_q       <= SCAN_S0;
      shadow_q     <= '0;
      anode_q      <= c_ANODE_OFF;
      seg_q        <= c_SEG_OFF;
      dp_q         <= c_DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode_select  = anode_q;
  assign segments      = seg_q;
  assign decimal_point = dp_q;
  assign frame_done    = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scanner
// Purpose  : Scoreboard bench for bcd_display_scanner (REFRESH_DIV=8,
//            BLANK_CYCLES=2, active-low outputs). The stimulus process
//            queues one expected {anode, segments, dp} entry per lit slot;
//            the monitor pops an entry whenever a lit digit appears and
//            checks it, plus run length, blanking, reset values and
//            frame_done period. Honours LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s0 = 4'd0, s1 = 4'd0, m0 = 4'd0, m1 = 4'd0;
  logic [3:0] anode_select;
  logic [6:0] segments;
  logic       decimal_point;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .REFRESH_DIV      (8),
    .BLANK_CYCLES     (2),
    .SEG_ACTIVE_LOW   (1'b1),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .digit_second_0 (s0),
    .digit_second_1 (s1),
    .digit_minute_0 (m0),
    .digit_minute_1 (m1),
    .anode_select   (anode_select),
    .segments       (segments),
    .decimal_point  (decimal_point),
    .frame_done     (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.anode = a;
    e.seg   = s;
    e.dp    = d;
    q.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame with digits 7, C, 3, 0 (hand-computed active-low glyphs)
  task automatic push_frame_7c30();
    push(4'b1110, 7'b1111000, 1'b1);
    push(4'b1101, 7'b0111111, 1'b1);
    push(4'b1011, 7'b0110000, 1'b0);
`ifndef LEADING_ZERO_BLANK_EN
    push(4'b0111, 7'b1000000, 1'b1);
`endif
  endtask

  // ---------------- Monitor ----------------
  int   cyc = 0;
  bit   rst_d1 = 1'b0, rst_d2 = 1'b0;
  int   run_len = 0;
  int   last_fd = -1;
  exp_t cur = '0;

  always @(posedge clk) begin
    cyc++;
    rst_d2 = rst_d1;
    rst_d1 = reset;
  end

  always @(negedge clk) begin
    if (rst_d1) begin
      chk("reset_anode", 32'(anode_select), 32'hF);
      chk("reset_seg", 32'(segments), 32'h7F);
      chk("reset_dp", 32'(decimal_point), 32'd1);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      run_len = 0;
      last_fd = -1;
    end else begin
      if (rst_d2) chk("frame_done_after_release", 32'(frame_done), 32'd1);
      if (anode_select != 4'hF) begin
        if (run_len == 0) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_lit: got anode %b expected none lit", anode_select);
          end else begin
            cur = q.pop_front();
          end
        end
        run_len++;
        chk("lit_anode", 32'(anode_select), 32'(cur.anode));
        chk("lit_seg", 32'(segments), 32'(cur.seg));
        chk("lit_dp", 32'(decimal_point), 32'(cur.dp));
      end else begin
        if (run_len != 0) chk("lit_run_length", 32'(run_len), 32'd6);
        run_len = 0;
        chk("blank_seg", 32'(segments), 32'h7F);
        chk("blank_dp", 32'(decimal_point), 32'd1);
      end
      if (frame_done) begin
        if (last_fd >= 0) chk("frame_done_period", 32'(cyc - last_fd), 32'd32);
        last_fd = cyc;
      end
    end
  end

  // ---------------- Stimulus ----------------
  initial begin
    // Three reset cycles
    wait_edges(3);

    // Frame 1: 5, 9, 3, 1
    s0 = 4'd5; s1 = 4'd9; m0 = 4'd3; m1 = 4'd1;
    push(4'b1110, 7'b0010010, 1'b1);
    push(4'b1101, 7'b0010000, 1'b1);
    push(4'b1011, 7'b0110000, 1'b0);
    push(4'b0111, 7'b1111001, 1'b1);
    reset = 1'b0;

    // Frame 2: seconds tens becomes 4'hC -> dash
    wait_edges(1);
    s1 = 4'hC;
    push(4'b1110, 7'b0010010, 1'b1);
    push(4'b1101, 7'b0111111, 1'b1);
    push(4'b1011, 7'b0110000, 1'b0);
    push(4'b0111, 7'b1111001, 1'b1);

    // During frame 2 slot M0: change S0 and M1; frame 2 must keep old values
    wait_edges(49);
    s0 = 4'd7; m1 = 4'd0;
    push_frame_7c30();                 // frame 3
    push(4'b1110, 7'b1111000, 1'b1);   // frame 4, cut short by reset in M0
    push(4'b1101, 7'b0111111, 1'b1);
    push(4'b1011, 7'b0110000, 1'b0);

    // Reset pulse two cycles into the lit part of frame 4 slot M0
    wait_edges(65);
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    push_frame_7c30();
    push_frame_7c30();

    // Two full frames after release, through the final trailing blank
    wait_edges(66);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
